// File: rtl/mmio_hub.sv
// MMIO window decoder: routes CPU accesses to NUM_SLOTS peripheral slots with wait states, timeout and error pulses.
// Optional fault register at the top halfword of the window is enabled by defining MMIO_FAULT_REG_EN.
module mmio_hub #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter int          WINDOW_BITS    = 8,
  parameter int          NUM_SLOTS      = 4,
  parameter int          SLOT_ADDR_BITS = 4,
  parameter int          TIMEOUT        = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        write_enable,
  input  logic                        byte_enable,
  input  logic                        byte_select,
  input  logic [15:0]                 addr,
  input  logic [15:0]                 data_in,
  output logic [15:0]                 data_out,
  output logic                        busy,
  output logic                        serviced_read,
  output logic                        serviced_write,
  output logic                        error,
  output logic [NUM_SLOTS-1:0]        slot_sel,
  output logic [SLOT_ADDR_BITS-1:0]   slot_addr,
  output logic                        slot_we,
  output logic [15:0]                 slot_wdata,
  input  logic [16*NUM_SLOTS-1:0]     slot_rdata,
  input  logic [NUM_SLOTS-1:0]        slot_ack
);
  localparam int IDX_W = WINDOW_BITS - SLOT_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_next;

  logic [15:0]          real_addr;
  logic [IDX_W-1:0]     idx;
  logic                 in_window, mapped, is_fault;
  logic [NUM_SLOTS-1:0] sel_onehot;
  logic                 ack_hit;
  logic [15:0]          ack_rdata;
  logic [7:0]           cnt;
  logic                 acc_we, acc_err, acc_unmapped;
  logic                 accept, finish_ack, finish_err;
  logic                 unused_addr_msb;

  assign unused_addr_msb = addr[15];
  assign real_addr = {addr[14:0], byte_enable ? byte_select : 1'b0};
  assign in_window = real_addr[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS];
  assign idx       = real_addr[WINDOW_BITS-1:SLOT_ADDR_BITS];
  assign mapped    = {1'b0, idx} < (IDX_W+1)'(NUM_SLOTS);

`ifdef MMIO_FAULT_REG_EN
  localparam logic [15:0] FAULT_ADDR = BASE_ADDR + 16'((1 << WINDOW_BITS) - 2);
  logic [7:0]       fault_count;
  logic             f_write, f_timeout;
  logic [3:0]       f_idx;
  logic [IDX_W-1:0] acc_idx;
  logic [15:0]      fault_word;
  assign is_fault   = in_window && (real_addr == FAULT_ADDR);
  assign fault_word = {fault_count, f_write, f_timeout, 2'b00, f_idx};
`else
  assign is_fault = 1'b0;
`endif

  // Slot decode and selected-lane ack/read-data mux; slot_sel is one-hot so an OR-style pick is exact.
  always_comb begin
    sel_onehot = '0;
    ack_hit    = 1'b0;
    ack_rdata  = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (idx == IDX_W'(k)) sel_onehot[k] = 1'b1;
      if (slot_sel[k]) begin
        ack_hit   = slot_ack[k];
        ack_rdata = slot_rdata[16*k +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    finish_ack     = 1'b0;
    finish_err     = 1'b0;
    busy           = 1'b0;
    serviced_read  = 1'b0;
    serviced_write = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE: accept = en && in_window;
      ACCESS: begin
        busy = 1'b1;
        // Ack is tested first so an ack on the final allowed cycle still completes cleanly.
        if (ack_hit)                          finish_ack = 1'b1;
        else if (acc_unmapped)                finish_err = 1'b1;
        else if (cnt + 8'd1 == 8'(TIMEOUT))   finish_err = 1'b1;
        if (finish_ack || finish_err) state_next = DONE;
      end
      DONE: begin
        serviced_read  = !acc_we;
        serviced_write = acc_we;
        error          = acc_err;
        state_next     = IDLE;
        accept         = en && in_window;
      end
      default: state_next = IDLE;
    endcase
    if (accept) state_next = is_fault ? DONE : ACCESS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out     <= '0;
      slot_sel     <= '0;
      slot_addr    <= '0;
      slot_we      <= 1'b0;
      slot_wdata   <= '0;
      cnt          <= '0;
      acc_we       <= 1'b0;
      acc_err      <= 1'b0;
      acc_unmapped <= 1'b0;
`ifdef MMIO_FAULT_REG_EN
      fault_count  <= '0;
      f_write      <= 1'b0;
      f_timeout    <= 1'b0;
      f_idx        <= '0;
      acc_idx      <= '0;
`endif
    end else begin
      if (accept) begin
        acc_we       <= write_enable;
        acc_err      <= 1'b0;
        acc_unmapped <= !mapped && !is_fault;
        cnt          <= '0;
        if (mapped && !is_fault) begin
          slot_sel   <= sel_onehot;
          slot_addr  <= real_addr[SLOT_ADDR_BITS-1:0];
          slot_we    <= write_enable;
          slot_wdata <= data_in;
        end
`ifdef MMIO_FAULT_REG_EN
        acc_idx <= idx;
        if (is_fault) begin
          if (write_enable) begin
            fault_count <= '0;
            f_write     <= 1'b0;
            f_timeout   <= 1'b0;
            f_idx       <= '0;
          end else begin
            data_out <= fault_word;
          end
        end
`endif
      end
      if (state == ACCESS && !ack_hit) cnt <= cnt + 8'd1;
      if (finish_ack || finish_err) begin
        slot_sel <= '0;
        acc_err  <= finish_err;
        if (!acc_we) data_out <= finish_ack ? ack_rdata : 16'h0000;
      end
`ifdef MMIO_FAULT_REG_EN
      // The register is updated as DONE is entered so a read accepted in that DONE cycle already sees it.
      if (finish_err) begin
        fault_count <= (fault_count == 8'hFF) ? fault_count : fault_count + 8'd1;
        f_write     <= acc_we;
        f_timeout   <= !acc_unmapped;
        f_idx       <= 4'(acc_idx);
      end
`endif
    end
  end
endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Parametrised successor to the fixed-address MMIO decoder.
- Decodes a byte-addressed MMIO window into NUM_SLOTS peripheral slots, each with its own select/ack handshake.
- Adds variable wait states, a timeout that always terminates an access, error reporting for unmapped addresses, and a registered read-data return.
- Sits between the CPU memory stage and peripherals (LEDs, UART, timers).

Parameters:
- BASE_ADDR, 16'hFF00: byte address of the MMIO window start; low WINDOW_BITS bits are zero.
- WINDOW_BITS, 8: window size is 2^WINDOW_BITS bytes.
- NUM_SLOTS, 4: number of peripheral slots, 1..16.
- SLOT_ADDR_BITS, 4: each slot spans 2^SLOT_ADDR_BITS bytes. Requires NUM_SLOTS*2^SLOT_ADDR_BITS <= 2^WINDOW_BITS.
- TIMEOUT, 15: cycles in ACCESS without ack before forced termination, 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  one-cycle request strobe from CPU
- write_enable  in  1  1 = write, 0 = read
- byte_enable  in  1  byte access
- byte_select  in  1  byte lane when byte_enable
- addr  in  16  word address
- data_in  in  16  write data
- data_out  out  16  registered read data
- busy  out  1  access in flight; requester must not pulse en
- serviced_read  out  1  one-cycle read completion pulse
- serviced_write  out  1  one-cycle write completion pulse
- error  out  1  one-cycle pulse, same cycle as serviced_*, on timeout or unmapped access
- slot_sel  out  NUM_SLOTS  one-hot select, held through access
- slot_addr  out  SLOT_ADDR_BITS  byte offset within slot
- slot_we  out  1  latched write_enable
- slot_wdata  out  16  latched data_in
- slot_rdata  in  16*NUM_SLOTS  slot k read data at [16k+15:16k]
- slot_ack  in  NUM_SLOTS  slot k completes access

Behaviour:
- Byte address: real_addr = {addr[14:0], byte_enable ? byte_select : 1'b0}.
- In window: real_addr[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS].
- Slot index: idx = real_addr[WINDOW_BITS-1:SLOT_ADDR_BITS]. Mapped iff idx < NUM_SLOTS.
- Reset (asserted): FSM = IDLE; all outputs 0, including data_out, slot_sel and the timeout counter. Applies asynchronously, including mid-access; the access is dropped with no completion pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, en high, window mapped (cycle N):
  - Latch slot_addr, slot_we, slot_wdata.
  - Set slot_sel[idx] and busy at N+1; go to ACCESS; clear the counter.
- IDLE, en high, in window but unmapped: busy at N+1, go to DONE with error flagged, read data 0.
- IDLE, en high, outside window: ignored; no pulses, busy stays 0.
- en while busy: ignored, no queuing.
- ACCESS, each cycle:
  - If slot_ack[selected] is high: capture slot_rdata lane on reads; drop slot_sel next cycle; go to DONE.
  - Else increment the counter. When it reaches TIMEOUT: drop slot_sel, capture data 0, flag error, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
  - slot_ack on non-selected lanes: ignored.
  - A slot may ack in its first select cycle (zero wait).
- DONE, one cycle:
  - serviced_read (read) or serviced_write (write) = 1, and error if flagged.
  - busy = 0 in the same cycle; next state IDLE. en may be accepted in this cycle; it is treated as in IDLE.
- Latency: zero-wait read with en at N gives sel at N+1, ack at N+1, serviced_read at N+2, data_out valid from N+2.
- data_out holds its value until the next read completion; writes never change it.
- slot_addr, slot_we and slot_wdata are stable while busy.

Optional Feature:
- Macro: MMIO_FAULT_REG_EN.
- When defined: adds a fault register at byte address BASE_ADDR + 2^WINDOW_BITS - 2, which must not overlap any slot.
  - Read returns {fault_count[7:0], last_was_write, last_was_timeout, 2'b0, last_idx[3:0]}.
  - fault_count saturates at 255.
  - A write clears the whole register.
  - Accesses complete via DONE one cycle after en, with no error.
  - Register resets to 0.
  - Each error pulse updates it.
- When undefined: that address decodes as ordinary (unmapped or slot) space.

Test Plan:
- Reset: hold rst low with slot_ack all 1 -> data_out=0, busy=0, slot_sel=0, all pulses 0. Release -> still idle.
- Zero-wait read:
  - en at N, addr=16'h7F81 (real_addr 16'hFF02, idx 0), slot 0 rdata=16'hA55A, ack tied high.
  - Expect slot_sel=4'b0001 at N+1; serviced_read and data_out=16'hA55A at N+2; busy high only at N+1.
- Waited write:
  - Write data 16'h1234 to real_addr 16'hFF24 (slot 2, slot_addr 4); ack asserted 3 cycles after sel.
  - Expect slot_wdata=16'h1234 stable throughout, serviced_write once, error=0, data_out unchanged.
- Timeout: read slot 1 with ack held 0 -> slot_sel drops after 15 ACCESS cycles; serviced_read and error pulse together; data_out=0.
- Unmapped and outside:
  - Read real_addr 16'hFF80 -> error and serviced_read 2 cycles after en, data_out=0, no slot_sel.
  - Read real_addr 16'h1000 -> no response.
  - en pulsed while busy -> ignored.
- MMIO_FAULT_REG_EN:
  - After the timeout above, read 16'hFFFE -> 16'h0141.
  - Write 16'hFFFE, then read -> 16'h0000.
